time_disp_fmt: RTL
==================

// Module: time_disp_fmt
// PURPOSE
//  Upstream stage of the 8-digit segment display. Takes DS1302 time samples (BCD hh:mm:ss)
//  and key events, and produces the 32-bit seg_bcd word, display enable and PM dot.
//  Provides a key-driven time-set mode with field blinking and a write request to the RTC writer.
// PARAMETERS
//  CLK_HZ          50_000_000  system clock frequency; sets the 1 s tick
//  BLINK_HALF_CYC  12_500_000  cycles per blink half-period (blink rate 2 Hz)
//  EDIT_TIMEOUT_S  10          seconds without a key before edit is abandoned
//  BLANK_NIBBLE    4'hF        code emitted for a blanked digit
//  SEP_NIBBLE      4'hA        code emitted at separator digits 2 and 5
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  rtc_valid   in   1   1-cycle strobe; rtc_hour/min/sec valid
//  rtc_hour    in   8   BCD hour, 24 h format, 0x00-0x23
//  rtc_min     in   8   BCD minute, 0x00-0x59
//  rtc_sec     in   8   BCD second, 0x00-0x59
//  key_valid   in   1   1-cycle strobe for a debounced key event
//  key_value   in   4   1=MODE 2=UP 3=DOWN 4=CANCEL; other codes are ignored
//  seg_bcd     out  32  {hT,hU,SEP,mT,mU,SEP,sT,sU}, MSB nibble = leftmost digit
//  seg_en      out  1   display enable
//  pm_flag     out  1   PM indicator (dot on digit 1)
//  wr_req      out  1   write request; level signal, held until wr_ack
//  wr_hour     out  8   BCD, 24 h; stable while wr_req=1
//  wr_min      out  8   BCD; stable while wr_req=1
//  wr_sec      out  8   BCD; stable while wr_req=1
//  wr_ack      in   1   1-cycle acknowledge from the RTC writer
// BEHAVIOUR
//  Reset: seg_bcd=32'h00A00A00, seg_en=0, pm_flag=0, wr_req=0, wr_*=0, state=VIEW, counters=0.
//  All outputs are registered. Input strobe at cycle N -> outputs updated at N+1.
//  Sample check: a sample is rejected (previous value held) if any nibble >9, hour>0x23, or min/sec>0x59.
//  The first accepted sample sets seg_en=1. seg_en stays 1 until the next reset.
//  FSM states: VIEW, ED_HOUR, ED_MIN, ED_SEC, COMMIT.
//   VIEW: accepted samples update the live registers and the display. MODE copies live
//     registers (including a same-cycle sample) into edit registers -> ED_HOUR.
//     MODE before the first valid sample is ignored.
//   ED_x: the display shows edit registers. rtc_valid updates live registers only.
//     UP/DOWN step the active field: hour 00..23, min/sec 00..59, wrap both ways (23->00, 00->23).
//     MODE: ED_HOUR->ED_MIN->ED_SEC->COMMIT. CANCEL -> VIEW, no write.
//     Timeout (EDIT_TIMEOUT_S seconds with no valid key) -> VIEW, no write.
//   COMMIT: wr_req=1, wr_*=edit registers. Keys and the timeout are ignored.
//     wr_ack -> wr_req=0 at the next edge, live registers = edit registers, -> VIEW.
//     wr_ack outside COMMIT is ignored.
//  Blink: the phase counter toggles every BLINK_HALF_CYC cycles in ED_x states.
//   Phase 1 blanks both digits of the active field (BLANK_NIBBLE).
//   Any valid key restarts the phase at 0 (field visible) and clears the timeout counter.
//  Timeout: a 1 s tick divider counts to CLK_HZ-1. The timeout counter runs in ED_x states only.
//  Reset mid-edit or mid-COMMIT: wr_req drops asynchronously and the FSM returns to VIEW.
// CONFIGURATION
//  H12_MODE_EN defined: hours are displayed 12 h. 00->12 AM, 01-11 AM, 12 PM, 13-23 -> 01-11 PM.
//   pm_flag=1 for source hours 12-23. Editing and wr_hour stay 24 h.
//  H12_MODE_EN undefined: hours are displayed 24 h. pm_flag is tied to 0.
// STRUCTURE
//  Package time_disp_pkg: key codes, FSM state encoding, HOUR_MAX=8'h23, MS_MAX=8'h59,
//   and the reset value of seg_bcd.
//  Sub-module bcd_field_step: combinational 2-digit BCD inc/dec with max and wrap.
//   One instance, muxed onto the active field.
// TESTING (CLK_HZ=1000, BLINK_HALF_CYC=10 in sim)
//  1. Reset, then sample 12:34:56 -> seg_bcd=32'h12A34A56 and seg_en=1 one cycle later.
//     With H12_MODE_EN: pm_flag=1.
//  2. Sample hour=0x24 or min=0x5A -> rejected, seg_bcd unchanged.
//     Before any valid sample, seg_en stays 0.
//  3. MODE, DOWN at hour 00 -> 23. MODE, UP at min 59 -> 00. MODE x2 -> wr_req=1, wr=23:00:ss.
//     wr_req is held 5 cycles until wr_ack, then drops next cycle and the display shows 23:00:ss.
//  4. In ED_MIN, idle 20 cycles -> digits 4,3 alternate BLANK_NIBBLE every 10 cycles.
//     A key forces them visible.
//  5. Enter edit, no keys for 10 s -> returns to VIEW, wr_req never asserted.
//     CANCEL gives the same result immediately.
//  6. H12_MODE_EN: samples 00:xx -> hour digits 12, pm=0; 13:xx -> 01, pm=1.
//     Without the macro: 13, pm=0. Reset during COMMIT -> wr_req=0 immediately.

Source files
------------

// File: rtl/time_disp_pkg.sv
// Shared types and constants for the time display formatter: key codes, FSM states,
// BCD field limits, reset display word, and BCD validation / 12 h conversion helpers.
package time_disp_pkg;

  typedef enum logic [3:0] {
    KEY_MODE   = 4'd1,
    KEY_UP     = 4'd2,
    KEY_DOWN   = 4'd3,
    KEY_CANCEL = 4'd4
  } key_e;

  typedef enum logic [2:0] {
    VIEW,
    ED_HOUR,
    ED_MIN,
    ED_SEC,
    COMMIT
  } state_e;

  localparam logic [7:0]  HOUR_MAX  = 8'h23;
  localparam logic [7:0]  MS_MAX    = 8'h59;
  localparam logic [31:0] SEG_RESET = 32'h00A00A00;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_val);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_val);
  endfunction

  // Returns {pm, bcd_hour_12}; input is a validated 24 h BCD hour.
  function automatic logic [8:0] hour_12(input logic [7:0] h);
    logic [4:0] bin;
    logic [4:0] b12;
    logic [8:0] res;
    bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (bin == 5'd0)       b12 = 5'd12;
    else if (bin > 5'd12)  b12 = bin - 5'd12;
    else                   b12 = bin;
    res[8]   = (bin >= 5'd12);
    res[7:0] = (b12 >= 5'd10) ? {4'd1, 4'(b12 - 5'd10)} : {4'd0, 4'(b12)};
    return res;
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Combinational two-digit BCD increment/decrement with wrap between 00 and max_val.
module bcd_field_step (
  input  logic [7:0] val,
  input  logic [7:0] max_val,
  input  logic       up,
  output logic [7:0] result
);

  always_comb begin
    result = val;
    if (up) begin
      if (val >= max_val)         result = '0;
      else if (val[3:0] >= 4'd9)  result = {val[7:4] + 4'd1, 4'd0};
      else                        result = {val[7:4], val[3:0] + 4'd1};
    end else begin
      if (val == '0)              result = max_val;
      else if (val[3:0] == 4'd0)  result = {val[7:4] - 4'd1, 4'd9};
      else                        result = {val[7:4], val[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/time_disp_fmt.sv
// RTC sample to 8-digit display formatter with key-driven time-set mode and RTC write request.
// Define H12_MODE_EN for 12 h hour display with PM flag; default build displays 24 h.
module time_disp_fmt
  import time_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned BLINK_HALF_CYC = 12_500_000,
  parameter int unsigned EDIT_TIMEOUT_S = 10,
  parameter logic [3:0]  BLANK_NIBBLE   = 4'hF,
  parameter logic [3:0]  SEP_NIBBLE     = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rtc_valid,
  input  logic [7:0]  rtc_hour,
  input  logic [7:0]  rtc_min,
  input  logic [7:0]  rtc_sec,
  input  logic        key_valid,
  input  logic [3:0]  key_value,
  output logic [31:0] seg_bcd,
  output logic        seg_en,
  output logic        pm_flag,
  output logic        wr_req,
  output logic [7:0]  wr_hour,
  output logic [7:0]  wr_min,
  output logic [7:0]  wr_sec,
  input  logic        wr_ack
);

  state_e      state, nxt_state;
  logic [7:0]  live_hour, live_min, live_sec;
  logic [7:0]  ed_hour, ed_min, ed_sec;
  logic [7:0]  nxt_live_hour, nxt_live_min, nxt_live_sec;
  logic [7:0]  nxt_ed_hour, nxt_ed_min, nxt_ed_sec;
  logic        nxt_wr_req;
  logic [7:0]  nxt_wr_hour, nxt_wr_min, nxt_wr_sec;
  logic [31:0] blink_cnt, nxt_blink_cnt;
  logic [31:0] tick_cnt, nxt_tick_cnt;
  logic [31:0] tmo_cnt, nxt_tmo_cnt;
  logic        phase, nxt_phase;
  logic        nxt_seg_en;
  logic [31:0] nxt_seg;
  logic        disp_pm;

  logic sample_ok, key_mode, key_up, key_down, key_cancel, key_any;
  logic editing, tick_end, tmo_end;
  logic [7:0] fld_val, fld_max, fld_step;
  logic [7:0] src_hour, src_min, src_sec, disp_hour;
  logic [7:0] hd, md, sd;

  assign sample_ok  = rtc_valid && bcd_ok(rtc_hour, HOUR_MAX) &&
                      bcd_ok(rtc_min, MS_MAX) && bcd_ok(rtc_sec, MS_MAX);
  assign key_mode   = key_valid && (key_value == KEY_MODE);
  assign key_up     = key_valid && (key_value == KEY_UP);
  assign key_down   = key_valid && (key_value == KEY_DOWN);
  assign key_cancel = key_valid && (key_value == KEY_CANCEL);
  assign key_any    = key_mode || key_up || key_down || key_cancel;
  assign editing    = state inside {ED_HOUR, ED_MIN, ED_SEC};
  assign tick_end   = (tick_cnt == CLK_HZ - 1);
  assign tmo_end    = editing && tick_end && (tmo_cnt == EDIT_TIMEOUT_S - 1);

  always_comb begin
    fld_val = ed_hour;
    fld_max = HOUR_MAX;
    case (state)
      ED_MIN: begin fld_val = ed_min; fld_max = MS_MAX; end
      ED_SEC: begin fld_val = ed_sec; fld_max = MS_MAX; end
      default: ;
    endcase
  end

  bcd_field_step u_step (
    .val     (fld_val),
    .max_val (fld_max),
    .up      (key_up),
    .result  (fld_step)
  );

  always_comb begin
    nxt_state     = state;
    nxt_live_hour = live_hour;
    nxt_live_min  = live_min;
    nxt_live_sec  = live_sec;
    nxt_ed_hour   = ed_hour;
    nxt_ed_min    = ed_min;
    nxt_ed_sec    = ed_sec;
    nxt_wr_req    = wr_req;
    nxt_wr_hour   = wr_hour;
    nxt_wr_min    = wr_min;
    nxt_wr_sec    = wr_sec;
    if (sample_ok) begin
      nxt_live_hour = rtc_hour;
      nxt_live_min  = rtc_min;
      nxt_live_sec  = rtc_sec;
    end
    case (state)
      VIEW: begin
        // A sample arriving with MODE is already valid and is the one copied.
        if (key_mode && (seg_en || sample_ok)) begin
          nxt_ed_hour = nxt_live_hour;
          nxt_ed_min  = nxt_live_min;
          nxt_ed_sec  = nxt_live_sec;
          nxt_state   = ED_HOUR;
        end
      end
      ED_HOUR, ED_MIN, ED_SEC: begin
        if (key_cancel) begin
          nxt_state = VIEW;
        end else if (key_mode) begin
          case (state)
            ED_HOUR: nxt_state = ED_MIN;
            ED_MIN:  nxt_state = ED_SEC;
            default: begin
              nxt_state   = COMMIT;
              nxt_wr_req  = 1'b1;
              nxt_wr_hour = ed_hour;
              nxt_wr_min  = ed_min;
              nxt_wr_sec  = ed_sec;
            end
          endcase
        end else if (key_up || key_down) begin
          case (state)
            ED_HOUR: nxt_ed_hour = fld_step;
            ED_MIN:  nxt_ed_min  = fld_step;
            default: nxt_ed_sec  = fld_step;
          endcase
        end else if (tmo_end) begin
          nxt_state = VIEW;
        end
      end
      COMMIT: begin
        if (wr_ack) begin
          nxt_wr_req    = 1'b0;
          nxt_live_hour = ed_hour;
          nxt_live_min  = ed_min;
          nxt_live_sec  = ed_sec;
          nxt_state     = VIEW;
        end
      end
      default: nxt_state = VIEW;
    endcase
  end

  always_comb begin
    nxt_blink_cnt = '0;
    nxt_phase     = 1'b0;
    nxt_tick_cnt  = '0;
    nxt_tmo_cnt   = '0;
    if (editing && !key_any) begin
      if (blink_cnt == BLINK_HALF_CYC - 1) begin
        nxt_phase = ~phase;
      end else begin
        nxt_phase     = phase;
        nxt_blink_cnt = blink_cnt + 32'd1;
      end
      if (tick_end) begin
        nxt_tmo_cnt = tmo_cnt + 32'd1;
      end else begin
        nxt_tmo_cnt  = tmo_cnt;
        nxt_tick_cnt = tick_cnt + 32'd1;
      end
    end
  end

  // Display is formatted from next-state values so it lands together with the state change.
  always_comb begin
    if (nxt_state == VIEW) begin
      src_hour = nxt_live_hour;
      src_min  = nxt_live_min;
      src_sec  = nxt_live_sec;
    end else begin
      src_hour = nxt_ed_hour;
      src_min  = nxt_ed_min;
      src_sec  = nxt_ed_sec;
    end
`ifdef H12_MODE_EN
    {disp_pm, disp_hour} = hour_12(src_hour);
`else
    disp_pm   = 1'b0;
    disp_hour = src_hour;
`endif
    hd = disp_hour;
    md = src_min;
    sd = src_sec;
    if (nxt_phase) begin
      case (nxt_state)
        ED_HOUR: hd = {2{BLANK_NIBBLE}};
        ED_MIN:  md = {2{BLANK_NIBBLE}};
        ED_SEC:  sd = {2{BLANK_NIBBLE}};
        default: ;
      endcase
    end
    nxt_seg    = {hd, SEP_NIBBLE, md, SEP_NIBBLE, sd};
    nxt_seg_en = seg_en || sample_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= VIEW;
      live_hour <= '0;
      live_min  <= '0;
      live_sec  <= '0;
      ed_hour   <= '0;
      ed_min    <= '0;
      ed_sec    <= '0;
      blink_cnt <= '0;
      tick_cnt  <= '0;
      tmo_cnt   <= '0;
      phase     <= 1'b0;
      seg_bcd   <= SEG_RESET;
      seg_en    <= 1'b0;
      pm_flag   <= 1'b0;
      wr_req    <= 1'b0;
      wr_hour   <= '0;
      wr_min    <= '0;
      wr_sec    <= '0;
    end else begin
      state     <= nxt_state;
      live_hour <= nxt_live_hour;
      live_min  <= nxt_live_min;
      live_sec  <= nxt_live_sec;
      ed_hour   <= nxt_ed_hour;
      ed_min    <= nxt_ed_min;
      ed_sec    <= nxt_ed_sec;
      blink_cnt <= nxt_blink_cnt;
      tick_cnt  <= nxt_tick_cnt;
      tmo_cnt   <= nxt_tmo_cnt;
      phase     <= nxt_phase;
      seg_en    <= nxt_seg_en;
      if (nxt_seg_en) begin
        seg_bcd <= nxt_seg;
        pm_flag <= disp_pm;
      end
      wr_req    <= nxt_wr_req;
      wr_hour   <= nxt_wr_hour;
      wr_min    <= nxt_wr_min;
      wr_sec    <= nxt_wr_sec;
    end
  end

endmodule
